// File: rtl/tcp_tx_scheduler_if.sv
// Connection-side TX mux control bundle: requests and shared-path handshakes in,
// one-hot grant, abort pulse and statistics out.
interface tcp_tx_scheduler_if #(
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = 16
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               hdr_valid;
  logic               hdr_ready;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               abort;
  logic [CNT_W-1:0]   pkt_count;
  logic [CNT_W-1:0]   timeout_count;

  modport master (
    input  enable, req, hdr_valid, hdr_ready, tvalid, tready, tlast,
    output grant, grant_valid, grant_idx, abort, pkt_count, timeout_count
  );

  modport slave (
    output enable, req, hdr_valid, hdr_ready, tvalid, tready, tlast,
    input  grant, grant_valid, grant_idx, abort, pkt_count, timeout_count
  );
endinterface

// File: rtl/tcp_tx_scheduler.sv
// Packet-level round-robin scheduler for the shared TCP TX IP path: one grant per
// IP packet (header then payload to tlast), with a watchdog that revokes stalled grants.
module tcp_tx_scheduler #(
  parameter int NUM_REQ        = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  tcp_tx_scheduler_if.master    bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, RELEASE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [IDX_W-1:0]     last_reg, last_next;
  logic [WD_W-1:0]      wd_reg, wd_next;
  logic                 abort_reg, abort_next;
  logic [CNT_W-1:0]     pkt_reg, pkt_next;
  logic [CNT_W-1:0]     to_reg, to_next;

  logic [NUM_REQ-1:0]   above_last;
  logic [NUM_REQ-1:0]   req_hi;
  logic [NUM_REQ-1:0]   pick_src;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;

  logic hdr_hs;
  logic beat;
  logic wd_expired;

  // Round robin: prefer requesters above the last grant, otherwise wrap to the lowest.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      assign above_last[gi]  = (IDX_W'(gi) > last_reg);
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  assign req_hi   = bus.req & above_last;
  assign pick_src = (|req_hi) ? req_hi : bus.req;

  always_comb begin
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pick_src[k]) pick_idx = IDX_W'(k);
    end
  end

  assign hdr_hs     = bus.hdr_valid && bus.hdr_ready;
  assign beat       = bus.tvalid && bus.tready;
  assign wd_expired = (wd_reg == WD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      idx_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
      wd_reg    <= '0;
      abort_reg <= 1'b0;
      pkt_reg   <= '0;
      to_reg    <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      wd_reg    <= wd_next;
      abort_reg <= abort_next;
      pkt_reg   <= pkt_next;
      to_reg    <= to_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    wd_next    = wd_reg;
    abort_next = 1'b0;
    pkt_next   = pkt_reg;
    to_next    = to_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.enable && (|bus.req)) begin
          grant_next = pick_onehot;
          idx_next   = pick_idx;
          last_next  = pick_idx;
          wd_next    = '0;
          state_next = HDR;
        end
      end

      HDR: begin
        if (hdr_hs) begin
          wd_next    = '0;
          state_next = PAYLOAD;
        end else if (wd_expired) begin
          grant_next = '0;
          abort_next = 1'b1;
          state_next = RELEASE;
          if (to_reg != {CNT_W{1'b1}}) to_next = to_reg + CNT_W'(1);
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end

      PAYLOAD: begin
        // A beat in the watchdog's final cycle counts as progress, so tlast beats timeout.
        if (beat) begin
          wd_next = '0;
          if (bus.tlast) begin
            grant_next = '0;
            pkt_next   = pkt_reg + CNT_W'(1);
            state_next = RELEASE;
          end
        end else if (wd_expired) begin
          grant_next = '0;
          abort_next = 1'b1;
          state_next = RELEASE;
          if (to_reg != {CNT_W{1'b1}}) to_next = to_reg + CNT_W'(1);
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end

      RELEASE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  assign bus.grant         = grant_reg;
  assign bus.grant_valid   = |grant_reg;
  assign bus.grant_idx     = idx_reg;
  assign bus.abort         = abort_reg;
  assign bus.pkt_count     = pkt_reg;
  assign bus.timeout_count = to_reg;
endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// Directed bench for tcp_tx_scheduler: a per-cycle vector table for a basic packet,
// then hand-written sequences for round robin, timeout, reset and enable corners.
module tb_tcp_tx_scheduler;
  localparam int N  = 8;
  localparam int T  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  tcp_tx_scheduler_if #(.NUM_REQ(N), .CNT_W(CW)) bus ();

  tcp_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  req;
    logic        en, hv, hr, tv, tr, tl;
    logic [7:0]  g;
    logic        gv;
    logic [2:0]  idx;
    logic        ab;
    logic [15:0] pkt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hs();
    bus.hdr_valid = 1'b0;
    bus.hdr_ready = 1'b0;
    bus.tvalid    = 1'b0;
    bus.tready    = 1'b0;
    bus.tlast     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_hs();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From a fresh grant: header, `beats` payload beats (tlast on the last), then
  // check the two grant-free cycles; returns when a following grant would be visible.
  task automatic run_packet(input int beats);
    bus.hdr_valid = 1'b1;
    bus.hdr_ready = 1'b1;
    tick();
    clear_hs();
    for (int b = 1; b <= beats; b++) begin
      bus.tvalid = 1'b1;
      bus.tready = 1'b1;
      bus.tlast  = (b == beats);
      tick();
    end
    clear_hs();
    chk("release_gap", 32'(bus.grant_valid), 32'd0);
    tick();
    chk("idle_gap", 32'(bus.grant_valid), 32'd0);
    tick();
  endtask

  initial begin
    int exp_idx;

    bus.enable = 1'b1;
    bus.req    = '0;
    clear_hs();

    vecs[0] = '{8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0, 16'd0};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 16'd1};
    vecs[8] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 16'd1};

    // Reset state
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_pkt", 32'(bus.pkt_count), 32'd0);
    chk("rst_to", 32'(bus.timeout_count), 32'd0);
    rst = 1'b0;

    // Single 5-beat packet for requester 3 (one stalled beat in the middle)
    for (int v = 0; v < 9; v++) begin
      bus.req       = vecs[v].req;
      bus.enable    = vecs[v].en;
      bus.hdr_valid = vecs[v].hv;
      bus.hdr_ready = vecs[v].hr;
      bus.tvalid    = vecs[v].tv;
      bus.tready    = vecs[v].tr;
      bus.tlast     = vecs[v].tl;
      tick();
      $display("[TB] vec %0d grant=%h idx=%0d pkt=%0d", v, bus.grant, bus.grant_idx, bus.pkt_count);
      chk($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(vecs[v].g));
      chk($sformatf("vec%0d_valid", v), 32'(bus.grant_valid), 32'(vecs[v].gv));
      chk($sformatf("vec%0d_idx", v), 32'(bus.grant_idx), 32'(vecs[v].idx));
      chk($sformatf("vec%0d_abort", v), 32'(bus.abort), 32'(vecs[v].ab));
      chk($sformatf("vec%0d_pkt", v), 32'(bus.pkt_count), 32'(vecs[v].pkt));
    end
    clear_hs();

    // Round robin over all requesters, 1-beat packets
    do_reset();
    bus.req = 8'hFF;
    tick();
    for (int p = 0; p < 9; p++) begin
      exp_idx = p % N;
      $display("[TB] rr pkt %0d grant=%h idx=%0d", p, bus.grant, bus.grant_idx);
      chk("rr_idx", 32'(bus.grant_idx), 32'(exp_idx));
      chk("rr_grant", 32'(bus.grant), 32'd1 << exp_idx);
      run_packet(1);
    end
    chk("rr_pkt", 32'(bus.pkt_count), 32'd9);

    // Two requesters alternate after last grant 2
    do_reset();
    bus.req = 8'h04;
    tick();
    chk("alt_first", 32'(bus.grant_idx), 32'd2);
    bus.req = 8'h24;
    run_packet(2);
    chk("alt_5a", 32'(bus.grant_idx), 32'd5);
    run_packet(1);
    chk("alt_2", 32'(bus.grant_idx), 32'd2);
    run_packet(1);
    chk("alt_5b", 32'(bus.grant_idx), 32'd5);
    $display("[TB] alternate done pkt=%0d", bus.pkt_count);

    // Timeout in HDR, then next requester granted two cycles later
    do_reset();
    bus.req = 8'h02;
    tick();
    chk("to_grant", 32'(bus.grant_idx), 32'd1);
    bus.req = 8'h06;
    idle_ticks(T - 1);
    chk("to_no_abort_early", 32'(bus.abort), 32'd0);
    chk("to_held_early", 32'(bus.grant_valid), 32'd1);
    tick();
    $display("[TB] timeout abort=%0d to=%0d", bus.abort, bus.timeout_count);
    chk("to_abort", 32'(bus.abort), 32'd1);
    chk("to_drop", 32'(bus.grant_valid), 32'd0);
    chk("to_count", 32'(bus.timeout_count), 32'd1);
    chk("to_pkt", 32'(bus.pkt_count), 32'd0);
    tick();
    chk("to_abort_once", 32'(bus.abort), 32'd0);
    chk("to_gap", 32'(bus.grant_valid), 32'd0);
    tick();
    chk("to_next_valid", 32'(bus.grant_valid), 32'd1);
    chk("to_next_idx", 32'(bus.grant_idx), 32'd2);
    chk("to_next_abort", 32'(bus.abort), 32'd0);

    // Beats in the watchdog's final cycle cancel the timeout
    bus.hdr_valid = 1'b1;
    bus.hdr_ready = 1'b1;
    tick();
    clear_hs();
    idle_ticks(T - 1);
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    tick();
    clear_hs();
    chk("last_beat_abort", 32'(bus.abort), 32'd0);
    chk("last_beat_held", 32'(bus.grant_valid), 32'd1);
    idle_ticks(T - 1);
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    bus.tlast  = 1'b1;
    tick();
    clear_hs();
    $display("[TB] final-cycle tlast pkt=%0d abort=%0d", bus.pkt_count, bus.abort);
    chk("last_tlast_abort", 32'(bus.abort), 32'd0);
    chk("last_tlast_drop", 32'(bus.grant_valid), 32'd0);
    chk("last_tlast_pkt", 32'(bus.pkt_count), 32'd1);
    chk("last_tlast_to", 32'(bus.timeout_count), 32'd1);

    // Reset mid-payload of requester 4
    do_reset();
    bus.req = 8'h10;
    tick();
    run_packet(1);
    chk("mid_idx", 32'(bus.grant_idx), 32'd4);
    chk("mid_pkt", 32'(bus.pkt_count), 32'd1);
    bus.hdr_valid = 1'b1;
    bus.hdr_ready = 1'b1;
    tick();
    clear_hs();
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    tick();
    clear_hs();
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("mid_rst_pkt", 32'(bus.pkt_count), 32'd0);
    rst = 1'b0;
    bus.req = 8'h11;
    tick();
    $display("[TB] post-reset grant=%h", bus.grant);
    chk("mid_rst_win", 32'(bus.grant), 32'h01);

    // Enable dropped mid-packet: packet completes, no new grant until re-enabled
    bus.enable    = 1'b0;
    bus.hdr_valid = 1'b1;
    bus.hdr_ready = 1'b1;
    tick();
    clear_hs();
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    bus.tlast  = 1'b1;
    tick();
    clear_hs();
    chk("en_pkt", 32'(bus.pkt_count), 32'd1);
    idle_ticks(3);
    chk("en_hold_off", 32'(bus.grant_valid), 32'd0);
    bus.enable = 1'b1;
    tick();
    $display("[TB] re-enabled grant=%h idx=%0d", bus.grant, bus.grant_idx);
    chk("en_regrant", 32'(bus.grant_idx), 32'd4);
    chk("en_regrant_valid", 32'(bus.grant_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
